// File: rtl/swg_physics_renderer_pkg.sv
// Shared constants and types for the moving-sprite engine.
package swg_physics_renderer_pkg;
  typedef enum logic {CIRCLE = 1'b0, SQUARE = 1'b1} shape_e;
  typedef enum logic {FULL_RESET = 1'b0, BOUNCE = 1'b1} bmode_e;

  localparam int X_DISPLAY = 640;
  localparam int Y_DISPLAY = 480;

  // True when a 12-bit signed candidate coordinate falls outside [lo, hi].
  function automatic logic out_lo(input logic signed [11:0] v, input int lo);
    return 32'(v) < lo;
  endfunction

  function automatic logic out_hi(input logic signed [11:0] v, input int hi);
    return 32'(v) > hi;
  endfunction
endpackage

// File: rtl/swg_physics_renderer_tick.sv
// Free-running period counter; tick is high during the last count of each period.
module tick_generator #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  output logic tick
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)      cnt <= '0;
    else if (!pause) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = reset && !pause && (cnt == LAST);
endmodule

// File: rtl/swg_physics_renderer.sv
// Sprite engine: display tick, stepped position integrator with boundary handling,
// and a per-pixel circle/square hit test against the current scan position.
module swg_physics_renderer
  import swg_physics_renderer_pkg::*;
#(
  parameter int     DELAY      = 1000,
  parameter int     STEP_DELAY = 833333,
  parameter int     A_INIT     = 16,
  parameter shape_e TYPE       = CIRCLE,
  parameter int     X_INIT     = 0,
  parameter int     Y_INIT     = 1,
  parameter int     X_MIN      = 0,
  parameter int     X_MAX      = 639,
  parameter int     Y_MIN      = 0,
  parameter int     Y_MAX      = 464,
  parameter int     VX_INIT    = 0,
  parameter int     VY_INIT    = 3,
  parameter bmode_e MODE       = FULL_RESET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic       wr_xy,
  input  logic       enabled,
  output logic       tick,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic       r,
  output logic       print
);
  localparam logic [9:0]         PX0 = 10'(X_INIT);
  localparam logic [9:0]         PY0 = 10'(Y_INIT);
  localparam logic signed [11:0] VX0 = 12'(VX_INIT);
  localparam logic signed [11:0] VY0 = 12'(VY_INIT);
  localparam int                 RAD = A_INIT / 2;
  localparam logic [21:0]        RR  = 22'(RAD * RAD);

  logic step;

  tick_generator #(.PERIOD(DELAY)) u_tick (
    .clk(clk), .reset(reset), .pause(pause), .tick(tick)
  );

  tick_generator #(.PERIOD(STEP_DELAY)) u_step (
    .clk(clk), .reset(reset), .pause(pause), .tick(step)
  );

  logic signed [11:0] vx, vy, vx_n, vy_n, nx, ny;
  logic [9:0]         px_n, py_n;
  logic               r_n, x_lo, x_hi, y_lo, y_hi;

  assign nx   = $signed({2'b00, px}) + vx;
  assign ny   = $signed({2'b00, py}) + vy;
  assign x_lo = out_lo(nx, X_MIN);
  assign x_hi = out_hi(nx, X_MAX);
  assign y_lo = out_lo(ny, Y_MIN);
  assign y_hi = out_hi(ny, Y_MAX);

  // step is already suppressed by pause inside the generator.
  always_comb begin
    px_n = px;
    py_n = py;
    vx_n = vx;
    vy_n = vy;
    r_n  = 1'b0;
    if (wr_xy) begin
      px_n = x_in;
      py_n = y_in;
    end else if (step) begin
      if (MODE == FULL_RESET && (x_lo || x_hi || y_lo || y_hi)) begin
        px_n = PX0;
        py_n = PY0;
        vx_n = VX0;
        vy_n = VY0;
        r_n  = 1'b1;
      end else begin
        px_n = x_lo ? 10'(X_MIN) : x_hi ? 10'(X_MAX) : nx[9:0];
        py_n = y_lo ? 10'(Y_MIN) : y_hi ? 10'(Y_MAX) : ny[9:0];
        vx_n = (x_lo || x_hi) ? -vx : vx;
        vy_n = (y_lo || y_hi) ? -vy : vy;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      px <= PX0;
      py <= PY0;
      vx <= VX0;
      vy <= VY0;
      r  <= 1'b0;
    end else begin
      px <= px_n;
      py <= py_n;
      vx <= vx_n;
      vy <= vy_n;
      r  <= r_n;
    end
  end

  // Hit test: square uses the half-open box, circle the squared distance to the centre.
  logic signed [10:0] dx, dy;
  logic signed [21:0] dxe, dye;
  logic [21:0]        dd;
  logic               in_sq, in_ci;

  assign dx    = {1'b0, x} - {1'b0, px} - 11'(RAD);
  assign dy    = {1'b0, y} - {1'b0, py} - 11'(RAD);
  assign dxe   = 22'(dx);
  assign dye   = 22'(dy);
  assign dd    = $unsigned(dxe * dxe + dye * dye);
  assign in_ci = dd <= RR;
  assign in_sq = ({1'b0, x} >= {1'b0, px}) && ({1'b0, x} < {1'b0, px} + 11'(A_INIT)) &&
                 ({1'b0, y} >= {1'b0, py}) && ({1'b0, y} < {1'b0, py} + 11'(A_INIT));

  assign print = reset && enabled && ((TYPE == SQUARE) ? in_sq : in_ci);
endmodule

// File: tb/tb_swg_physics_renderer.sv
// Scoreboard bench: a falling circle (FULL_RESET) and a bouncing square side by side.
module tb_swg_physics_renderer;
  import swg_physics_renderer_pkg::*;

  logic       clk = 1'b0;
  logic       reset, pause, wr_xy, enabled;
  logic [9:0] x, y, x_in, y_in;
  logic       tick1, r1, print1, tick2, r2, print2;
  logic [9:0] px1, py1, px2, py2;

  always #5 clk = ~clk;

  swg_physics_renderer #(
    .DELAY(4), .STEP_DELAY(2), .A_INIT(8), .TYPE(CIRCLE), .X_INIT(10), .Y_INIT(1),
    .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(20), .VX_INIT(0), .VY_INIT(3), .MODE(FULL_RESET)
  ) dut1 (
    .clk(clk), .reset(reset), .pause(pause), .x(x), .y(y), .x_in(x_in), .y_in(y_in),
    .wr_xy(wr_xy), .enabled(enabled), .tick(tick1), .px(px1), .py(py1), .r(r1), .print(print1)
  );

  swg_physics_renderer #(
    .DELAY(4), .STEP_DELAY(2), .A_INIT(8), .TYPE(SQUARE), .X_INIT(10), .Y_INIT(2),
    .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(20), .VX_INIT(0), .VY_INIT(-3), .MODE(BOUNCE)
  ) dut2 (
    .clk(clk), .reset(reset), .pause(pause), .x(x), .y(y), .x_in(x_in), .y_in(y_in),
    .wr_xy(wr_xy), .enabled(enabled), .tick(tick2), .px(px2), .py(py2), .r(r2), .print(print2)
  );

  typedef struct { int cyc; int sig; int val; } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   base = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int smp(input int s);
    case (s)
      0: return int'(tick1);
      1: return int'(px1);
      2: return int'(py1);
      3: return int'(r1);
      4: return int'(print1);
      5: return int'(py2);
      6: return int'(r2);
      7: return int'(print2);
      8: return int'(px2);
      default: return -1;
    endcase
  endfunction

  function automatic string nm(input int s);
    case (s)
      0: return "tick";
      1: return "px";
      2: return "py";
      3: return "r";
      4: return "print_circle";
      5: return "py_bounce";
      6: return "r_bounce";
      7: return "print_square";
      8: return "px_bounce";
      default: return "?";
    endcase
  endfunction

  // Monitor: outputs are sampled 1 time unit after the falling edge.
  always begin
    @(negedge clk);
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        total++;
        if (smp(sb[i].sig) != sb[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", nm(sb[i].sig), sb[i].cyc - base + 1,
                   smp(sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic want(input int c, input int s, input int v);
    exp_t e;
    e.cyc = base + c - 1;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    repeat (base + c - 1 - cyc) @(negedge clk);
  endtask

  int py1_tab[17] = '{1, 1, 4, 4, 7, 7, 10, 10, 13, 13, 16, 16, 19, 19, 1, 1, 4};
  int py2_tab[17] = '{2, 2, 0, 0, 3, 3, 6, 6, 9, 9, 12, 12, 15, 15, 18, 18, 20};
  int hx[8]  = '{104, 104, 100, 107, 108, 109, 104, 107};
  int hy[8]  = '{54, 50, 50, 54, 50, 54, 54, 57};
  int hen[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
  int hp1[8] = '{1, 1, 0, 1, 0, 0, 0, 0};
  int hp2[8] = '{1, 1, 1, 1, 0, 0, 0, 1};

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; pause = 1'b0; wr_xy = 1'b0; enabled = 1'b1;
    x = 10'd14; y = 10'd5; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    base = cyc;
    // Scan point sits on both sprites' init positions, yet reset forces print low.
    want(1, 0, 0); want(1, 1, 10); want(1, 2, 1); want(1, 3, 0); want(1, 4, 0);
    want(1, 5, 2); want(1, 7, 0); want(1, 8, 10);
    #1;
    total++;
    if (px1 !== 10'd10) begin
      bad++;
      $display("FAIL px_reset cyc=1 got=%0d want=10", px1);
    end
    total++;
    if (py1 !== 10'd1) begin
      bad++;
      $display("FAIL py_reset cyc=1 got=%0d want=1", py1);
    end
    total++;
    if (print1 !== 1'b0) begin
      bad++;
      $display("FAIL print_reset cyc=1 got=%0d want=0", print1);
    end
    total++;
    if (py2 !== 10'd2) begin
      bad++;
      $display("FAIL py_bounce_reset cyc=1 got=%0d want=2", py2);
    end

    @(negedge clk);
    reset = 1'b1;
    base = cyc;
    for (int c = 1; c <= 17; c++) begin
      want(c, 0, int'(c % 4 == 0));
      want(c, 2, py1_tab[c-1]);
      want(c, 3, int'(c == 15));
      want(c, 5, py2_tab[c-1]);
      want(c, 6, 0);
    end
    want(1, 4, 1); want(1, 7, 1);

    goto(18);
    pause = 1'b1;
    for (int c = 18; c <= 27; c++) begin
      want(c, 0, 0); want(c, 2, 4); want(c, 3, 0);
    end
    want(28, 0, 0); want(28, 2, 4); want(29, 0, 0); want(29, 2, 7);
    want(30, 0, 1); want(31, 2, 10);
    goto(28);
    pause = 1'b0;

    // Load lands on a step cycle; the step must be dropped.
    goto(32);
    wr_xy = 1'b1; x_in = 10'd100; y_in = 10'd50;
    want(33, 1, 100); want(33, 2, 50); want(33, 3, 0); want(33, 8, 100); want(33, 5, 50);
    for (int i = 0; i < 8; i++) begin
      want(33 + i, 4, hp1[i]);
      want(33 + i, 7, hp2[i]);
    end
    want(40, 2, 50); want(40, 1, 100);
    for (int i = 0; i < 8; i++) begin
      goto(33 + i);
      wr_xy = 1'b0; pause = 1'b1;
      x = 10'(hx[i]); y = 10'(hy[i]); enabled = hen[i][0];
    end

    goto(41);
    pause = 1'b0; reset = 1'b0; x = 10'd104; y = 10'd54; enabled = 1'b1;
    want(41, 0, 0); want(41, 4, 0); want(41, 7, 0);
    want(42, 1, 10); want(42, 2, 1); want(42, 3, 0); want(42, 5, 2); want(42, 6, 0);
    goto(43);
    reset = 1'b1;
    base = cyc;
    // Bounce velocity must be back to -3 after the mid-run reset.
    want(3, 5, 0); want(3, 6, 0); want(3, 2, 4); want(4, 0, 1); want(5, 5, 3);
    goto(6);
    repeat (2) @(negedge clk);
    #2;
    while (sb.size() > 0) begin
      bad++;
      $display("FAIL unchecked_%s cyc=%0d got=none want=%0d", nm(sb[0].sig), sb[0].cyc, sb[0].val);
      sb.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
